// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Reusable elastic pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries a data payload plus a control field that is forced to zero when
//   the stage holds no valid entry, so downstream never sees write enables
//   from a bubble. Supports valid/ready handshake and synchronous flush.
//
// Optional feature macro:
//   PIPE_STAGE_SKID_EN
//     defined   : 2-entry skid buffer, in_ready is decoded from the state
//                 register only (no combinational ready path), occupancy 0..2.
//     undefined : single register, in_ready = out_ready || !out_valid,
//                 occupancy 0..1, no skid registers.
//
// Handshake:
//   An entry moves on a rising edge where valid && ready are both high on the
//   same side (in_valid/in_ready upstream, out_valid/out_ready downstream).
//   valid must not depend on ready.
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous active-high reset, highest priority
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream presents an entry
//   in_ready   out  stage can accept an entry
//   in_data    in   upstream payload  [DATA_W]
//   in_ctrl    in   upstream control  [CTRL_W]
//   out_valid  out  head entry present
//   out_ready  in   downstream accepts head entry
//   out_data   out  payload of head entry [DATA_W]
//   out_ctrl   out  control of head entry, 0 when out_valid=0 [CTRL_W]
//   occupancy  out  entries held; equals the FSM state encoding, so it also
//                   serves as the state debug view
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 7,
    parameter logic [DATA_W-1:0] DATA_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Encoding chosen so the state value is the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] w_data_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic              w_load_main;
    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_load_skid;

    // Ready is a pure decode of the state register: stall chains stay registered.
    assign w_in_ready = (r_state != ST_SKID);
`else
    assign w_in_ready = out_ready || !w_out_valid;
`endif

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    // Next-state and main-register load selection.
    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_data_nxt  = in_data;
        w_ctrl_nxt  = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
        w_load_skid = 1'b0;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end
`ifdef PIPE_STAGE_SKID_EN
                else if (w_in_fire) begin
                    // Downstream stalled: park the new entry, keep head stable.
                    w_state_nxt = ST_SKID;
                    w_load_skid = 1'b1;
                end
`endif
                else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_SKID: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_FULL;
                    w_load_main = 1'b1;
                    w_data_nxt  = r_skid_data;
                    w_ctrl_nxt  = r_skid_ctrl;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // rst and flush produce the identical cleared state; any concurrent
    // input fire is discarded.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ST_EMPTY;
            r_data  <= DATA_RST;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_data <= w_data_nxt;
                r_ctrl <= w_ctrl_nxt;
            end
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_skid_data <= DATA_RST;
            r_skid_ctrl <= '0;
        end else if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
        end
    end
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_data;
    assign out_ctrl  = w_out_valid ? r_ctrl : '0;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. Inputs change on the falling edge; the
// registered outputs are examined 1 time unit after the rising edge. A
// scoreboard queue tracks accepted entries and checks delivery order.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DATA_W   = 32;
  localparam int          CTRL_W   = 7;
  localparam logic [31:0] DATA_RST = 32'h0;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              flush     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data   = '0;
  logic [CTRL_W-1:0] in_ctrl   = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .DATA_RST (DATA_RST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  // ------------------------------------------------------------------ scoring
  int n_tests = 0;
  int n_fail  = 0;
  logic [CTRL_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake bookkeeping for the cycle whose inputs are currently applied.
  task automatic sb_sample();
    logic [CTRL_W+DATA_W-1:0] head;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", {31'h0, out_valid}, 64'h0);
        end else begin
          head = exp_q.pop_front();
          check("sb_data", 64'(out_data), 64'(head[DATA_W-1:0]));
          check("sb_ctrl", 64'(out_ctrl), 64'(head[CTRL_W+DATA_W-1:DATA_W]));
        end
      end
      if (in_valid && in_ready && !flush) exp_q.push_back({in_ctrl, in_data});
      if (flush) exp_q.delete();
    end else begin
      exp_q.delete();
    end
  endtask

  // ------------------------------------------------------------------ drivers
  // Apply one cycle of inputs; returns 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [1:0] occ,
                           input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    check({tag, "_valid"}, 64'(out_valid), 64'(v));
    check({tag, "_occ"},   64'(occupancy), 64'(occ));
    check({tag, "_data"},  64'(out_data),  64'(d));
    check({tag, "_ctrl"},  64'(out_ctrl),  64'(c));
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    // Reset held two cycles while upstream presents an entry.
    rst = 1'b1;
    cycle(1'b1, 32'hDEADBEEF, 7'h55, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 7'h55, 1'b0, 1'b0);
    chk_state("reset", 1'b0, 2'd0, DATA_RST, 7'h0);
    check("reset_in_ready", 64'(in_ready), 64'h1);
    rst = 1'b0;
    idle(1'b1);
    chk_state("post_reset", 1'b0, 2'd0, DATA_RST, 7'h0);

    // Streaming, one entry per cycle.
    cycle(1'b1, 32'h10, 7'h41, 1'b1, 1'b0);
    chk_state("stream0", 1'b1, 2'd1, 32'h10, 7'h41);
    cycle(1'b1, 32'h11, 7'h41, 1'b1, 1'b0);
    chk_state("stream1", 1'b1, 2'd1, 32'h11, 7'h41);
    cycle(1'b1, 32'h12, 7'h41, 1'b1, 1'b0);
    chk_state("stream2", 1'b1, 2'd1, 32'h12, 7'h41);
    idle(1'b1);
    chk_state("stream_end", 1'b0, 2'd0, 32'h12, 7'h0);

    // Backpressure.
    cycle(1'b1, 32'hA0, 7'h03, 1'b0, 1'b0);
    chk_state("bp0", 1'b1, 2'd1, 32'hA0, 7'h03);
`ifdef PIPE_STAGE_SKID_EN
    check("bp0_in_ready", 64'(in_ready), 64'h1);
    cycle(1'b1, 32'hA1, 7'h05, 1'b0, 1'b0);
    chk_state("bp1", 1'b1, 2'd2, 32'hA0, 7'h03);
    check("bp1_in_ready", 64'(in_ready), 64'h0);
    cycle(1'b1, 32'hA2, 7'h06, 1'b0, 1'b0);
    chk_state("bp2_held", 1'b1, 2'd2, 32'hA0, 7'h03);
    cycle(1'b1, 32'hA2, 7'h06, 1'b1, 1'b0);
    chk_state("bp_drain0", 1'b1, 2'd1, 32'hA1, 7'h05);
    cycle(1'b1, 32'hA2, 7'h06, 1'b1, 1'b0);
    chk_state("bp_drain1", 1'b1, 2'd1, 32'hA2, 7'h06);
`else
    check("bp0_in_ready_stall", 64'(in_ready), 64'h0);
    cycle(1'b1, 32'hA1, 7'h05, 1'b0, 1'b0);
    chk_state("bp1_held", 1'b1, 2'd1, 32'hA0, 7'h03);
    check("bp1_in_ready", 64'(in_ready), 64'h0);
    // Ready follows out_ready without a clock edge.
    out_ready = 1'b1;
    #1;
    check("bp_comb_ready", 64'(in_ready), 64'h1);
    cycle(1'b1, 32'hA1, 7'h05, 1'b1, 1'b0);
    chk_state("bp_drain0", 1'b1, 2'd1, 32'hA1, 7'h05);
    cycle(1'b1, 32'hA2, 7'h06, 1'b1, 1'b0);
    chk_state("bp_drain1", 1'b1, 2'd1, 32'hA2, 7'h06);
`endif
    idle(1'b1);
    chk_state("bp_end", 1'b0, 2'd0, 32'hA2, 7'h0);

    // Flush with entries held; the offered entry must be dropped.
    cycle(1'b1, 32'hB0, 7'h11, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    cycle(1'b1, 32'hB1, 7'h12, 1'b0, 1'b0);
    chk_state("fl_pre", 1'b1, 2'd2, 32'hB0, 7'h11);
`else
    chk_state("fl_pre", 1'b1, 2'd1, 32'hB0, 7'h11);
`endif
    cycle(1'b1, 32'hB2, 7'h13, 1'b0, 1'b1);
    chk_state("flush", 1'b0, 2'd0, DATA_RST, 7'h0);
    idle(1'b1);
    chk_state("flush_after", 1'b0, 2'd0, DATA_RST, 7'h0);

    // Flush during an output fire: head delivered, offered entry dropped.
    cycle(1'b1, 32'hC0, 7'h21, 1'b1, 1'b0);
    chk_state("flfire_pre", 1'b1, 2'd1, 32'hC0, 7'h21);
    cycle(1'b1, 32'hC1, 7'h22, 1'b1, 1'b1);
    chk_state("flfire", 1'b0, 2'd0, DATA_RST, 7'h0);
    idle(1'b1);
    chk_state("flfire_after", 1'b0, 2'd0, DATA_RST, 7'h0);

    // rst and flush together while FULL.
    cycle(1'b1, 32'hD0, 7'h31, 1'b0, 1'b0);
    chk_state("rstfl_pre", 1'b1, 2'd1, 32'hD0, 7'h31);
    rst = 1'b1;
    cycle(1'b1, 32'hD1, 7'h32, 1'b0, 1'b1);
    rst = 1'b0;
    chk_state("rstfl", 1'b0, 2'd0, DATA_RST, 7'h0);
    check("rstfl_in_ready", 64'(in_ready), 64'h1);
    idle(1'b1);

    // Bubble: valid toggles 1,0,1.
    cycle(1'b1, 32'hE0, 7'h7F, 1'b1, 1'b0);
    chk_state("bub0", 1'b1, 2'd1, 32'hE0, 7'h7F);
    idle(1'b1);
    chk_state("bub1", 1'b0, 2'd0, 32'hE0, 7'h00);
    cycle(1'b1, 32'hE1, 7'h7F, 1'b1, 1'b0);
    chk_state("bub2", 1'b1, 2'd1, 32'hE1, 7'h7F);
    idle(1'b1);
    chk_state("bub_end", 1'b0, 2'd0, 32'hE1, 7'h00);

    check("sb_drain", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
